alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit two-operand registered datapath (operands `a`, `b`, result `out`) between two requesters. It accepts operand pairs over a request/grant handshake, drives the datapath operand inputs, and waits a fixed datapath latency. It then captures the result and returns it to the winning requester with a one-cycle done pulse. It sits between the requester logic and the datapath instance, which is instantiated alongside it and wired to the `dp_*` ports.

---
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 tb/tb_alu_share_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer that shares one registered two-operand
// datapath between two requesters and returns each result with a done pulse.
module alu_share_arbiter #(
  parameter int W      = 4,
  parameter int DP_LAT = 1   // datapath latency in edges, legal range 1..7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res0,
  output logic [W-1:0] res1,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  input  logic [W-1:0] dp_out,
  output logic         busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] LAT = 3'(DP_LAT);

  state_t       state, state_d;
  logic         owner, owner_d;
  logic         last, last_d;
  logic [2:0]   cnt, cnt_d;
  logic [W-1:0] dp_a_d, dp_b_d, res0_d, res1_d;
  logic         gnt0_d, gnt1_d, done0_d, done1_d;
  logic         sel;

  assign busy = (state == BUSY);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d = state;
    owner_d = owner;
    last_d  = last;
    cnt_d   = cnt;
    dp_a_d  = dp_a;
    dp_b_d  = dp_b;
    res0_d  = res0;
    res1_d  = res1;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    sel     = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          sel     = (req0 && req1) ? ~last : req1;
          owner_d = sel;
          dp_a_d  = sel ? a1 : a0;
          dp_b_d  = sel ? b1 : b0;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          cnt_d   = LAT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt - 3'd1;
        if (cnt == 3'd1) begin
          if (owner) res1_d = dp_out;
          else       res0_d = dp_out;
          done0_d = ~owner;
          done1_d = owner;
          last_d  = owner;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= 3'd0;
      dp_a  <= '0;
      dp_b  <= '0;
      res0  <= '0;
      res1  <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      last  <= last_d;
      cnt   <= cnt_d;
      dp_a  <= dp_a_d;
      dp_b  <= dp_b_d;
      res0  <= res0_d;
      res1  <= res1_d;
      gnt0  <= gnt0_d;
      gnt1  <= gnt1_d;
      done0 <= done0_d;
      done1 <= done1_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with DP_LAT=1 and one with
// DP_LAT=3 share stimulus, each feeding an (a+b) mod 16 stub datapath.
module tb_alu_share_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;

  logic         l1_gnt0, l1_gnt1, l1_done0, l1_done1, l1_busy;
  logic [W-1:0] l1_res0, l1_res1, l1_dp_a, l1_dp_b, l1_dp_out;
  logic         l3_gnt0, l3_gnt1, l3_done0, l3_done1, l3_busy;
  logic [W-1:0] l3_res0, l3_res1, l3_dp_a, l3_dp_b, l3_dp_out;
  logic [W-1:0] l3_s1, l3_s2;

  logic [3:0]   l1_pulses, l3_pulses;
  assign l1_pulses = {l1_gnt0, l1_gnt1, l1_done0, l1_done1};
  assign l3_pulses = {l3_gnt0, l3_gnt1, l3_done0, l3_done1};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // The operand registers inside the arbiter are the first datapath stage.
  assign l1_dp_out = l1_dp_a + l1_dp_b;
  always_ff @(posedge clk) begin
    l3_s1 <= l3_dp_a + l3_dp_b;
    l3_s2 <= l3_s1;
  end
  assign l3_dp_out = l3_s2;

  alu_share_arbiter #(.W(W), .DP_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(l1_gnt0), .gnt1(l1_gnt1), .done0(l1_done0), .done1(l1_done1),
    .res0(l1_res0), .res1(l1_res1), .dp_a(l1_dp_a), .dp_b(l1_dp_b),
    .dp_out(l1_dp_out), .busy(l1_busy)
  );

  alu_share_arbiter #(.W(W), .DP_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(l3_gnt0), .gnt1(l3_gnt1), .done0(l3_done0), .done1(l3_done1),
    .res0(l3_res0), .res1(l3_res1), .dp_a(l3_dp_a), .dp_b(l3_dp_b),
    .dp_out(l3_dp_out), .busy(l3_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) step();
    checks++;
    if ({l1_pulses, l1_busy, l1_res0, l1_res1, l1_dp_a, l1_dp_b} !== 21'h0) begin
      errors++;
      $display("FAIL reset_l1: got %h expected 0",
               {l1_pulses, l1_busy, l1_res0, l1_res1, l1_dp_a, l1_dp_b});
    end
    checks++;
    if ({l3_pulses, l3_busy, l3_res0, l3_res1, l3_dp_a, l3_dp_b} !== 21'h0) begin
      errors++;
      $display("FAIL reset_l3: got %h expected 0",
               {l3_pulses, l3_busy, l3_res0, l3_res1, l3_dp_a, l3_dp_b});
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({l1_pulses, l1_busy, l3_pulses, l3_busy} !== 10'h0) begin
        errors++;
        $display("FAIL release_quiet[%0d]: got %b expected 0", i,
                 {l1_pulses, l1_busy, l3_pulses, l3_busy});
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd10;
    step();  // E0
    checks++;
    if ({l1_pulses, l1_busy, l1_dp_a, l1_dp_b} !== {4'b1000, 1'b1, 4'd3, 4'd10}) begin
      errors++;
      $display("FAIL single_gnt: got %h expected %h",
               {l1_pulses, l1_busy, l1_dp_a, l1_dp_b}, {4'b1000, 1'b1, 4'd3, 4'd10});
    end
    req0 = 1'b0;
    step();  // E0+1
    checks++;
    if ({l1_pulses, l1_busy, l1_res0, l1_res1} !== {4'b0010, 1'b0, 4'd13, 4'd0}) begin
      errors++;
      $display("FAIL single_done: got %h expected %h",
               {l1_pulses, l1_busy, l1_res0, l1_res1}, {4'b0010, 1'b0, 4'd13, 4'd0});
    end
    step();
    checks++;
    if ({l1_pulses, l1_busy, l1_res0} !== {4'b0000, 1'b0, 4'd13}) begin
      errors++;
      $display("FAIL single_hold: got %h expected %h",
               {l1_pulses, l1_busy, l1_res0}, {4'b0000, 1'b0, 4'd13});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [8];
    exp_seq = '{4'b1000, 4'b0010, 4'b0100, 4'b0001,
                4'b1000, 4'b0010, 4'b0100, 4'b0001};
    do_reset();
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd10;
    req1 = 1'b1; a1 = 4'd9; b1 = 4'd10;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (l1_pulses !== exp_seq[i]) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got %b expected %b", i, l1_pulses, exp_seq[i]);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if ({l1_res0, l1_res1} !== {4'd11, 4'd3}) begin
      errors++;
      $display("FAIL rr_results: got %h expected %h", {l1_res0, l1_res1}, {4'd11, 4'd3});
    end
  endtask

  task automatic test_latency3();
    do_reset();
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd5;
    step();  // E0
    checks++;
    if ({l3_pulses, l3_busy} !== 5'b1000_1) begin
      errors++;
      $display("FAIL lat3_gnt0: got %b expected %b", {l3_pulses, l3_busy}, 5'b1000_1);
    end
    req0 = 1'b0;
    req1 = 1'b1; a1 = 4'd4; b1 = 4'd4;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({l3_gnt1, l3_done0, l3_busy} !== {1'b0, (k == 3), (k != 3)}) begin
        errors++;
        $display("FAIL lat3_wait[%0d]: got %b expected %b", k,
                 {l3_gnt1, l3_done0, l3_busy}, {1'b0, (k == 3), (k != 3)});
      end
    end
    checks++;
    if (l3_res0 !== 4'd7) begin
      errors++;
      $display("FAIL lat3_res0: got %0d expected 7", l3_res0);
    end
    step();  // E0+4
    checks++;
    if (l3_pulses !== 4'b0100) begin
      errors++;
      $display("FAIL lat3_gnt1: got %b expected 0100", l3_pulses);
    end
    req1 = 1'b0;
    repeat (3) step();
    checks++;
    if ({l3_pulses, l3_res1} !== {4'b0001, 4'd8}) begin
      errors++;
      $display("FAIL lat3_done1: got %h expected %h", {l3_pulses, l3_res1}, {4'b0001, 4'd8});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req1 = 1'b1; a1 = 4'd7; b1 = 4'd10;
    step();  // E0
    checks++;
    if (l3_pulses !== 4'b0100) begin
      errors++;
      $display("FAIL abort_gnt1: got %b expected 0100", l3_pulses);
    end
    req1 = 1'b0;
    step();  // E0+1
    step();  // E0+2
    reset = 1'b1;
    #1;
    checks++;
    if ({l3_pulses, l3_busy, l3_res0, l3_res1, l3_dp_a, l3_dp_b} !== 21'h0) begin
      errors++;
      $display("FAIL abort_async: got %h expected 0",
               {l3_pulses, l3_busy, l3_res0, l3_res1, l3_dp_a, l3_dp_b});
    end
    step();  // E0+3, capture edge had the operation survived
    checks++;
    if ({l3_done1, l3_res1} !== 5'h0) begin
      errors++;
      $display("FAIL abort_no_done: got %h expected 0", {l3_done1, l3_res1});
    end
    reset = 1'b0;
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd1;
    req1 = 1'b1;
    step();
    checks++;
    if (l3_pulses !== 4'b1000) begin
      errors++;
      $display("FAIL abort_tie: got %b expected 1000", l3_pulses);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_drop();
    do_reset();
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd6;
    req1 = 1'b1; a1 = 4'd2; b1 = 4'd2;
    step();  // E0
    checks++;
    if (l1_pulses !== 4'b1000) begin
      errors++;
      $display("FAIL drop_gnt0: got %b expected 1000", l1_pulses);
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({l1_gnt1, l1_done1, l1_res1} !== 6'h0) begin
        errors++;
        $display("FAIL drop_quiet[%0d]: got %h expected 0", i, {l1_gnt1, l1_done1, l1_res1});
      end
    end
    checks++;
    if (l1_res0 !== 4'd11) begin
      errors++;
      $display("FAIL drop_res0: got %0d expected 11", l1_res0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_latency3();
    test_reset_mid();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
